sum_splitter: RTL and testbench

- Receive-side counterpart of the combinational pair adder (out_a = a+b, out_b = b+c).
- Accepts a stream of {sum_ab, sum_bc, b} triples over a valid/ready handshake and recovers the original operands: a = sum_ab - b, c = sum_bc - b.
- Buffers the results in a DEPTH-entry FIFO with its own valid/ready output handshake and a delivered-transaction counter.
- Sits downstream of the adder and feeds operand-check or scoreboard logic.

---
 rtl/sum_splitter.sv | 112 +++++++++++
 tb/tb_sum_splitter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sum_splitter.sv
// sum_splitter: recovers operands a and c from {a+b, b+c, b} triples and
// buffers them in a small FIFO with a delivered-transaction counter.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high on that interface. The producer holds its payload stable while
// valid && !ready. valid may drop without a transfer. in_ready depends only on
// registered state (never on out_ready). out_valid/out_a/out_c come from
// registered state only, so there is no input-to-output bypass.
module sum_splitter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_sum_ab,
  input  logic [WIDTH-1:0]           in_sum_bc,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_c,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_c [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level_q;
  logic [CNT_W-1:0] count_q;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] diff_a;
  logic [WIDTH-1:0] diff_c;

  // Handshake qualifiers and the operand recovery (modulo 2^WIDTH, borrow dropped).
  always_comb begin
    in_ready  = (level_q != FULL_LVL);
    out_valid = (level_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    diff_a    = in_sum_ab - in_b;
    diff_c    = in_sum_bc - in_b;
  end

  // Head entry is shown only while valid; zero otherwise.
  always_comb begin
    out_a = '0;
    out_c = '0;
    if (out_valid) begin
      out_a = mem_a[rptr];
      out_c = mem_c[rptr];
    end
  end

  // FIFO storage write on push; cleared on reset so no stale data survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_c[i] <= '0;
      end
    end else if (push) begin
      mem_a[wptr] <= diff_a;
      mem_c[wptr] <= diff_c;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + LW'(1);
    end else if (pop && !push) begin
      level_q <= level_q - LW'(1);
    end
  end

  // Delivered-transaction counter, wraps without saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign level = level_q;
  assign count = count_q;

endmodule

// File: tb/tb_sum_splitter.sv
// Directed testbench for sum_splitter with hand-computed expectations.
module tb_sum_splitter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum_ab;
  logic [WIDTH-1:0] in_sum_bc;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_c;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_err    = 0;

  sum_splitter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum_ab (in_sum_ab),
    .in_sum_bc (in_sum_bc),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_c     (out_c),
    .level     (level),
    .count     (count)
  );

  // Clock: 10 time-unit period, first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ab, input logic [7:0] bc, input logic [7:0] b);
    in_valid  = v;
    in_sum_ab = ab;
    in_sum_bc = bc;
    in_b      = b;
  endtask

  logic [7:0] base_cnt;

  initial begin
    // Reset held for 3 cycles with in_valid high.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 8'h01);
    step(); step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a",     32'(out_a),     32'd0);
    chk("rst_out_c",     32'(out_c),     32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_level",    32'(level),    32'd0);

    // Single transfer: a=3-2=1, c=5-2=3.
    drive(1'b1, 8'd3, 8'd5, 8'd2);
    #1 chk("no_bypass_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_a",     32'(out_a),     32'd1);
    chk("single_c",     32'(out_c),     32'd3);
    chk("single_level", 32'(level),     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_valid", 32'(out_valid), 32'd0);
    chk("single_pop_count", 32'(count),     32'd1);
    chk("single_pop_a_zero", 32'(out_a),    32'd0);

    // Wrap arithmetic: 0x02-0x05=0xFD, 0x00-0x05=0xFB.
    drive(1'b1, 8'h02, 8'h00, 8'h05);
    step();
    in_valid = 1'b0;
    chk("wrap_a", 32'(out_a), 32'hFD);
    chk("wrap_c", 32'(out_c), 32'hFB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wrap_count", 32'(count), 32'd2);

    // Full/backpressure: a=n, c=n+16, b=0.
    for (int n = 1; n <= 4; n++) begin
      drive(1'b1, 8'(n), 8'(n + 16), 8'd0);
      step();
    end
    chk("full_level",    32'(level),    32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'd5, 8'd21, 8'd0);
    step();
    chk("full_held_level", 32'(level), 32'd4);
    chk("full_head_a",     32'(out_a), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_pop_level",    32'(level),    32'd3);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    chk("full_pop_count",    32'(count),    32'd3);
    step();
    in_valid = 1'b0;
    chk("fifth_accepted_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int n = 2; n <= 5; n++) begin
      #1;
      chk($sformatf("drain_a_%0d", n), 32'(out_a), 32'(n));
      chk($sformatf("drain_c_%0d", n), 32'(out_c), 32'(n + 16));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(count),     32'd7);

    // Streaming with pointer wrap: a=n, c=2n, b=7.
    base_cnt  = 8'(count);
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      drive(1'b1, 8'(n + 7), 8'(2 * n + 7), 8'd7);
      step();
      chk($sformatf("stream_a_%0d", n),     32'(out_a), 32'(n));
      chk($sformatf("stream_c_%0d", n),     32'(out_c), 32'(2 * n));
      chk($sformatf("stream_level_%0d", n), 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_level_end", 32'(level), 32'd0);
    chk("stream_count",     32'(count), 32'(base_cnt) + 32'd10);

    // Reset mid-operation with three entries buffered.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 8'(n + 40), 8'(n + 50), 8'd0);
      step();
    end
    in_valid = 1'b0;
    chk("pre_mid_rst_level", 32'(level), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_level",    32'(level),     32'd0);
    chk("mid_rst_count",    32'(count),     32'd0);
    chk("mid_rst_out_a",    32'(out_a),     32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    chk("after_rst_valid", 32'(out_valid), 32'd0);
    chk("after_rst_count", 32'(count),     32'd0);
    out_ready = 1'b0;
    drive(1'b1, 8'd9, 8'd4, 8'd1);
    step();
    in_valid = 1'b0;
    chk("fresh_a",     32'(out_a), 32'd8);
    chk("fresh_c",     32'(out_c), 32'd3);
    chk("fresh_level", 32'(level), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
